dma_priority_arbiter: RTL and testbench

- Four-channel DREQ arbiter and hold-request sequencer for the 8237A-compatible DMA controller.
- Samples the channel request pins, applies polarity, mask and controller-disable qualification, and resolves one winner by fixed or rotating priority.
- Runs the HRQ/HLDA handshake with the CPU and drives the selected channel's DACK until the timing FSM reports end of service.
- Feeds channel select and priority state to the transfer timing FSM and the register file.

---
 rtl/dma_priority_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dma_priority_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter: four-channel DREQ arbiter and HRQ/HLDA sequencer for
// an 8237A-compatible DMA controller. Requests are polarity-corrected and
// synchronised, then qualified by mask and controller disable. One winner is
// picked by fixed or rotating priority. The grant is then held locked until
// the timing FSM reports end of service or the CPU withdraws HLDA.
module dma_priority_arbiter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] DREQ,
    input  logic       dreq_active_low,
    input  logic       dack_active_high,
    input  logic       rotating_pri,
    input  logic       ctrl_disable,
    input  logic [3:0] mask,
    input  logic       HLDA,
    input  logic       service_done,
    output logic       HRQ,
    output logic [3:0] DACK,
    output logic [3:0] ch_sel,
    output logic [1:0] ch_id,
    output logic       grant_valid,
    output logic [7:0] ch_priority
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        GRANT = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_sync [SYNC_STAGES];
    logic [3:0] w_req_pol;
    logic [3:0] w_valid;
    logic       w_any_valid;
    logic [1:0] r_top;
    logic [1:0] r_winner;
    logic [1:0] w_winner;
    logic [3:0] w_grant_onehot;

    // Flip raw pins so that a 1 always means "requesting" before synchronising.
    assign w_req_pol   = DREQ ^ {4{dreq_active_low}};
    assign w_valid     = r_sync[SYNC_STAGES-1] & ~mask;
    assign w_any_valid = (|w_valid) & ~ctrl_disable;

    // Synchroniser chain on the polarity-corrected requests; clears to "not requesting".
    // NOTE: sequential state uses <= so every flop samples pre-edge values, making the chain shift correctly.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= 4'b0000;
            end
        end else begin
            r_sync[0] <= w_req_pol;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Per-channel priority level: distance from the current top channel.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            ch_priority[2*n +: 2] = 2'(n) - r_top;
        end
    end

    // Pick the first valid channel searching upward from top, wrapping mod 4.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        logic found;
        logic [1:0] idx;
        w_winner = r_top;
        found    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = r_top + 2'(k);
            if (!found && w_valid[idx]) begin
                w_winner = idx;
                found    = 1'b1;
            end
        end
    end

    // Rotation pointer: held at 0 in fixed mode, advanced past the winner on end of service.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_top <= 2'd0;
        end else if (!rotating_pri) begin
            r_top <= 2'd0;
        end else if (r_state == GRANT && service_done) begin
            r_top <= r_winner + 2'd1;
        end
    end

    // Latch the winner when HLDA is seen in REQ, so the grant cannot move afterwards.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_winner <= 2'd0;
        end else if (r_state == REQ && HLDA && w_any_valid) begin
            r_winner <= w_winner;
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic for the hold-request handshake.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_any_valid) begin
                    w_next_state = REQ;
                end
            end
            REQ: begin
                if (HLDA) begin
                    w_next_state = w_any_valid ? GRANT : IDLE;
                end
            end
            GRANT: begin
                // service_done and a dropped HLDA both end the grant; rotation is handled above.
                if (service_done || !HLDA) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_grant_onehot = 4'b0001 << r_winner;

    // Output decode from the registered state and latched winner.
    always_comb begin
        HRQ         = 1'b0;
        grant_valid = 1'b0;
        ch_sel      = 4'b0000;
        ch_id       = 2'd0;
        DACK        = {4{~dack_active_high}};
        case (r_state)
            REQ: begin
                HRQ = 1'b1;
            end
            GRANT: begin
                HRQ         = 1'b1;
                grant_valid = 1'b1;
                ch_sel      = w_grant_onehot;
                ch_id       = r_winner;
                DACK        = dack_active_high ? w_grant_onehot : ~w_grant_onehot;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed testbench for dma_priority_arbiter: one table row per clock cycle,
// followed by a hand-written asynchronous-reset-in-GRANT sequence.
module tb_dma_priority_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] DREQ;
    logic       dreq_active_low;
    logic       dack_active_high;
    logic       rotating_pri;
    logic       ctrl_disable;
    logic [3:0] mask;
    logic       HLDA;
    logic       service_done;
    logic       HRQ;
    logic [3:0] DACK;
    logic [3:0] ch_sel;
    logic [1:0] ch_id;
    logic       grant_valid;
    logic [7:0] ch_priority;

    int n_compared   = 0;
    int n_mismatched = 0;

    dma_priority_arbiter #(.SYNC_STAGES(2)) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .DREQ             (DREQ),
        .dreq_active_low  (dreq_active_low),
        .dack_active_high (dack_active_high),
        .rotating_pri     (rotating_pri),
        .ctrl_disable     (ctrl_disable),
        .mask             (mask),
        .HLDA             (HLDA),
        .service_done     (service_done),
        .HRQ              (HRQ),
        .DACK             (DACK),
        .ch_sel           (ch_sel),
        .ch_id            (ch_id),
        .grant_valid      (grant_valid),
        .ch_priority      (ch_priority)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] dreq;
        logic [3:0] mask;
        logic       rot;
        logic       dal;
        logic       dah;
        logic       dis;
        logic       hlda;
        logic       done;
        logic       hrq;
        logic [3:0] dack;
        logic [3:0] chsel;
        logic [7:0] pri;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] dreq, input logic [3:0] msk, input logic rot,
                       input logic dal, input logic dah, input logic dis,
                       input logic hlda, input logic done,
                       input logic hrq, input logic [3:0] dack, input logic [3:0] chsel,
                       input logic [7:0] pri);
        vec_t v;
        v.dreq = dreq; v.mask = msk; v.rot = rot; v.dal = dal; v.dah = dah;
        v.dis = dis; v.hlda = hlda; v.done = done;
        v.hrq = hrq; v.dack = dack; v.chsel = chsel; v.pri = pri;
        vq.push_back(v);
    endtask

    function automatic logic [1:0] enc(input logic [3:0] oh);
        case (oh)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all(input string tag, input logic hrq, input logic [3:0] dack,
                             input logic [3:0] chsel, input logic [7:0] pri);
        check({tag, ".HRQ"},         8'(HRQ),         8'(hrq));
        check({tag, ".DACK"},        8'(DACK),        8'(dack));
        check({tag, ".ch_sel"},      8'(ch_sel),      8'(chsel));
        check({tag, ".ch_id"},       8'(ch_id),       8'(enc(chsel)));
        check({tag, ".grant_valid"}, 8'(grant_valid), 8'(|chsel));
        check({tag, ".ch_priority"}, ch_priority,     pri);
    endtask

    initial begin
        // dreq     mask     rot dal dah dis hlda done | hrq dack     chsel    pri
        // Fixed priority, active-high DREQ, active-low DACK
        add(4'b1010, 4'b0000, 0, 0, 0, 0, 0, 0,  0, 4'b1111, 4'b0000, 8'hE4);
        add(4'b1010, 4'b0000, 0, 0, 0, 0, 0, 0,  0, 4'b1111, 4'b0000, 8'hE4);
        add(4'b1010, 4'b0000, 0, 0, 0, 0, 0, 0,  1, 4'b1111, 4'b0000, 8'hE4);
        add(4'b1010, 4'b0000, 0, 0, 0, 0, 1, 0,  1, 4'b1101, 4'b0010, 8'hE4);
        add(4'b0001, 4'b0000, 0, 0, 0, 0, 1, 0,  1, 4'b1101, 4'b0010, 8'hE4);
        add(4'b0001, 4'b0000, 0, 0, 0, 0, 1, 1,  0, 4'b1111, 4'b0000, 8'hE4);
        add(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0,  1, 4'b1111, 4'b0000, 8'hE4);
        add(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0,  1, 4'b1111, 4'b0000, 8'hE4);
        add(4'b0000, 4'b0000, 0, 0, 0, 0, 1, 0,  0, 4'b1111, 4'b0000, 8'hE4);
        // Mask, then controller disable while in REQ
        add(4'b0100, 4'b0100, 0, 0, 0, 0, 0, 0,  0, 4'b1111, 4'b0000, 8'hE4);
        add(4'b0100, 4'b0100, 0, 0, 0, 0, 0, 0,  0, 4'b1111, 4'b0000, 8'hE4);
        add(4'b0100, 4'b0100, 0, 0, 0, 0, 0, 0,  0, 4'b1111, 4'b0000, 8'hE4);
        add(4'b0100, 4'b0000, 0, 0, 0, 0, 0, 0,  1, 4'b1111, 4'b0000, 8'hE4);
        add(4'b0100, 4'b0000, 0, 0, 0, 1, 0, 0,  1, 4'b1111, 4'b0000, 8'hE4);
        add(4'b0100, 4'b0000, 0, 0, 0, 1, 1, 0,  0, 4'b1111, 4'b0000, 8'hE4);
        add(4'b0000, 4'b0000, 0, 0, 0, 1, 0, 0,  0, 4'b1111, 4'b0000, 8'hE4);
        add(4'b0000, 4'b0000, 0, 0, 0, 1, 0, 0,  0, 4'b1111, 4'b0000, 8'hE4);
        // Inverted polarities: active-low DREQ pin 2, active-high DACK
        add(4'b1011, 4'b0000, 0, 1, 1, 0, 0, 0,  0, 4'b0000, 4'b0000, 8'hE4);
        add(4'b1011, 4'b0000, 0, 1, 1, 0, 0, 0,  0, 4'b0000, 4'b0000, 8'hE4);
        add(4'b1011, 4'b0000, 0, 1, 1, 0, 0, 0,  1, 4'b0000, 4'b0000, 8'hE4);
        add(4'b1011, 4'b0000, 0, 1, 1, 0, 1, 0,  1, 4'b0100, 4'b0100, 8'hE4);
        add(4'b1011, 4'b0000, 0, 1, 1, 0, 1, 1,  0, 4'b0000, 4'b0000, 8'hE4);
        add(4'b0000, 4'b1111, 0, 0, 0, 0, 0, 0,  0, 4'b1111, 4'b0000, 8'hE4);
        add(4'b0000, 4'b1111, 0, 0, 0, 0, 0, 0,  0, 4'b1111, 4'b0000, 8'hE4);
        add(4'b0000, 4'b1111, 1, 0, 0, 0, 0, 0,  0, 4'b1111, 4'b0000, 8'hE4);
        // Rotating priority, all four channels requesting
        add(4'b1111, 4'b1111, 1, 0, 0, 0, 0, 0,  0, 4'b1111, 4'b0000, 8'hE4);
        add(4'b1111, 4'b1111, 1, 0, 0, 0, 0, 0,  0, 4'b1111, 4'b0000, 8'hE4);
        add(4'b1111, 4'b0000, 1, 0, 0, 0, 0, 0,  1, 4'b1111, 4'b0000, 8'hE4);
        add(4'b1111, 4'b0000, 1, 0, 0, 0, 1, 0,  1, 4'b1110, 4'b0001, 8'hE4);
        add(4'b1111, 4'b0000, 1, 0, 0, 0, 1, 1,  0, 4'b1111, 4'b0000, 8'h93);
        add(4'b1111, 4'b0000, 1, 0, 0, 0, 0, 0,  1, 4'b1111, 4'b0000, 8'h93);
        add(4'b1111, 4'b0000, 1, 0, 0, 0, 1, 0,  1, 4'b1101, 4'b0010, 8'h93);
        add(4'b1111, 4'b0000, 1, 0, 0, 0, 1, 1,  0, 4'b1111, 4'b0000, 8'h4E);
        add(4'b1111, 4'b0000, 1, 0, 0, 0, 0, 0,  1, 4'b1111, 4'b0000, 8'h4E);
        add(4'b1111, 4'b0000, 1, 0, 0, 0, 1, 0,  1, 4'b1011, 4'b0100, 8'h4E);
        add(4'b1111, 4'b0000, 1, 0, 0, 0, 1, 1,  0, 4'b1111, 4'b0000, 8'h39);
        add(4'b1111, 4'b0000, 1, 0, 0, 0, 0, 0,  1, 4'b1111, 4'b0000, 8'h39);
        add(4'b1111, 4'b0000, 1, 0, 0, 0, 1, 0,  1, 4'b0111, 4'b1000, 8'h39);
        // HLDA revoked in GRANT on ch3: no rotation
        add(4'b1111, 4'b0000, 1, 0, 0, 0, 0, 0,  0, 4'b1111, 4'b0000, 8'h39);
        add(4'b1111, 4'b0000, 1, 0, 0, 0, 0, 0,  1, 4'b1111, 4'b0000, 8'h39);
        add(4'b1111, 4'b0000, 1, 0, 0, 0, 1, 0,  1, 4'b0111, 4'b1000, 8'h39);
        // service_done coincident with HLDA drop: rotation wins
        add(4'b1111, 4'b0000, 1, 0, 0, 0, 0, 1,  0, 4'b1111, 4'b0000, 8'hE4);
        add(4'b1111, 4'b0000, 1, 0, 0, 0, 0, 0,  1, 4'b1111, 4'b0000, 8'hE4);
        add(4'b1111, 4'b0000, 1, 0, 0, 0, 1, 0,  1, 4'b1110, 4'b0001, 8'hE4);
        add(4'b1111, 4'b0000, 1, 0, 0, 0, 1, 1,  0, 4'b1111, 4'b0000, 8'h93);
        // Clearing rotating_pri forces top back to 0
        add(4'b1111, 4'b1111, 0, 0, 0, 0, 0, 0,  0, 4'b1111, 4'b0000, 8'hE4);
        // Set up a grant on ch1 with top=1 for the reset sequence
        add(4'b1111, 4'b0000, 1, 0, 0, 0, 0, 0,  1, 4'b1111, 4'b0000, 8'hE4);
        add(4'b1111, 4'b0000, 1, 0, 0, 0, 1, 0,  1, 4'b1110, 4'b0001, 8'hE4);
        add(4'b1111, 4'b0000, 1, 0, 0, 0, 1, 1,  0, 4'b1111, 4'b0000, 8'h93);
        add(4'b1111, 4'b0000, 1, 0, 0, 0, 0, 0,  1, 4'b1111, 4'b0000, 8'h93);
        add(4'b1111, 4'b0000, 1, 0, 0, 0, 1, 0,  1, 4'b1101, 4'b0010, 8'h93);

        // Reset and idle inputs
        RESET            = 1'b1;
        DREQ             = 4'b0000;
        dreq_active_low  = 1'b0;
        dack_active_high = 1'b0;
        rotating_pri     = 1'b0;
        ctrl_disable     = 1'b0;
        mask             = 4'b0000;
        HLDA             = 1'b0;
        service_done     = 1'b0;
        #12;
        check_all("reset", 1'b0, 4'b1111, 4'b0000, 8'hE4);
        @(negedge CLK);
        RESET = 1'b0;
        tick();

        foreach (vq[i]) begin
            DREQ             = vq[i].dreq;
            mask             = vq[i].mask;
            rotating_pri     = vq[i].rot;
            dreq_active_low  = vq[i].dal;
            dack_active_high = vq[i].dah;
            ctrl_disable     = vq[i].dis;
            HLDA             = vq[i].hlda;
            service_done     = vq[i].done;
            tick();
            check_all($sformatf("vec%0d", i), vq[i].hrq, vq[i].dack, vq[i].chsel, vq[i].pri);
        end

        // Asynchronous reset between edges while granting ch1 with top=1
        HLDA         = 1'b1;
        service_done = 1'b0;
        #2;
        RESET = 1'b1;
        #1;
        check_all("async_rst", 1'b0, 4'b1111, 4'b0000, 8'hE4);
        #2;
        RESET = 1'b0;
        HLDA  = 1'b0;

        // Sync flops were cleared: requests need two edges again, HRQ on the third
        tick();
        check("post_rst_e1.HRQ", 8'(HRQ), 8'd0);
        tick();
        check("post_rst_e2.HRQ", 8'(HRQ), 8'd0);
        tick();
        check("post_rst_e3.HRQ", 8'(HRQ), 8'd1);
        check("post_rst_e3.ch_priority", ch_priority, 8'hE4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
